// File: rtl/ex_mem_reg_pkg.sv
// rtl/ex_mem_reg_pkg.sv - shared pipeline types for the EX/MEM stage register
package ex_mem_reg_pkg;

  // Occupancy states; the encoding doubles as the entry count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } pipe_state_t;

  // Everything that travels from execute to memory with one instruction.
  typedef struct packed {
    logic        regWrite;
    logic        memToReg;
    logic        memWrite;
    logic [31:0] ALUOut;
    logic [31:0] writeData;
    logic [4:0]  writeReg;
  } stage_payload_t;

  localparam int PAYLOAD_W = $bits(stage_payload_t);

  // A result is forwardable only when it is a real register write that does
  // not wait for a load and does not target the hardwired zero register.
  function automatic logic can_forward(input logic valid, input stage_payload_t p);
    return valid && p.regWrite && !p.memToReg && (p.writeReg != 5'd0);
  endfunction

endpackage

// File: rtl/ex_mem_reg_payload.sv
// rtl/ex_mem_reg_payload.sv - enable-loaded stage payload register with synchronous clear
module pipe_payload_reg
  import ex_mem_reg_pkg::*;
(
  input  logic           clk,
  input  logic           resetN,
  input  logic           clr,
  input  logic           load,
  input  stage_payload_t d,
  output stage_payload_t q
);

  // Clear wins over load so a drained slot never keeps stale contents.
  always_ff @(posedge clk) begin
    if (!resetN || clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with handshake, optional skid buffer (EX_MEM_SKID_EN)
module ex_mem_reg
  import ex_mem_reg_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  input  logic        validE,
  input  logic        regWriteE,
  input  logic        memToRegE,
  input  logic        memWriteE,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] writeDataE,
  input  logic [4:0]  writeRegE,
  input  logic        flushE,
  input  logic        readyM,
  output logic        readyE,
  output logic        validM,
  output logic        regWriteM,
  output logic        memToRegM,
  output logic        memWriteM,
  output logic [31:0] ALUOutM,
  output logic [31:0] writeDataM,
  output logic [4:0]  writeRegM,
  output logic        fwdValid,
  output logic [4:0]  fwdReg,
  output logic [31:0] fwdData,
  output logic [1:0]  occupancy
);

  pipe_state_t    state;
  pipe_state_t    state_n;
  stage_payload_t e_payload;
  stage_payload_t main_d;
  stage_payload_t main_q;
  logic           in_xfer;
  logic           out_xfer;
  logic           main_load;
  logic           main_clr;

  assign e_payload = '{regWrite:  regWriteE,
                       memToReg:  memToRegE,
                       memWrite:  memWriteE,
                       ALUOut:    ALUOutE,
                       writeData: writeDataE,
                       writeReg:  writeRegE};

  assign validM   = (state != ST_EMPTY);
  assign out_xfer = validM && readyM;
  assign in_xfer  = validE && readyE && !flushE;

`ifdef EX_MEM_SKID_EN
  stage_payload_t skid_q;
  logic           skid_load;
  logic           skid_clr;
  logic           readyE_q;

  // Registered ready breaks the readyM -> readyE path; the skid slot absorbs
  // the one entry that can arrive while memory stalls.
  assign readyE = readyE_q;
`else
  // Without a skid slot, accept only when the held entry is leaving or absent.
  assign readyE = readyM || !validM;
`endif

  // Next-state and payload steering for each occupancy case.
  always_comb begin
    state_n   = state;
    main_load = 1'b0;
    main_clr  = 1'b0;
    main_d    = e_payload;
`ifdef EX_MEM_SKID_EN
    skid_load = 1'b0;
    skid_clr  = 1'b0;
`endif
    unique case (state)
      ST_EMPTY: begin
        if (in_xfer) begin
          main_load = 1'b1;
          state_n   = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_xfer && out_xfer) begin
          main_load = 1'b1;
        end else if (in_xfer) begin
`ifdef EX_MEM_SKID_EN
          skid_load = 1'b1;
          state_n   = ST_SKID;
`endif
        end else if (out_xfer) begin
          main_clr = 1'b1;
          state_n  = ST_EMPTY;
        end
      end
`ifdef EX_MEM_SKID_EN
      ST_SKID: begin
        if (out_xfer) begin
          main_load = 1'b1;
          main_d    = skid_q;
          skid_clr  = 1'b1;
          state_n   = ST_FULL;
        end
      end
`endif
      default: state_n = ST_EMPTY;
    endcase
  end

  // Occupancy state; reset discards whatever was in flight.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_n;
    end
  end

  pipe_payload_reg u_main (
    .clk    (clk),
    .resetN (resetN),
    .clr    (main_clr),
    .load   (main_load),
    .d      (main_d),
    .q      (main_q)
  );

`ifdef EX_MEM_SKID_EN
  // Ready for the next cycle is known from the next state alone.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      readyE_q <= 1'b1;
    end else begin
      readyE_q <= (state_n != ST_SKID);
    end
  end

  pipe_payload_reg u_skid (
    .clk    (clk),
    .resetN (resetN),
    .clr    (skid_clr),
    .load   (skid_load),
    .d      (e_payload),
    .q      (skid_q)
  );
`endif

  assign regWriteM  = validM && main_q.regWrite;
  assign memWriteM  = validM && main_q.memWrite;
  assign memToRegM  = main_q.memToReg;
  assign ALUOutM    = main_q.ALUOut;
  assign writeDataM = main_q.writeData;
  assign writeRegM  = main_q.writeReg;

  assign fwdValid   = can_forward(validM, main_q);
  assign fwdReg     = main_q.writeReg;
  assign fwdData    = main_q.ALUOut;

  assign occupancy  = state;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg against a queue model
module tb_ex_mem_reg;
  import ex_mem_reg_pkg::*;

  logic        clk;
  logic        resetN;
  logic        validE, regWriteE, memToRegE, memWriteE;
  logic [31:0] ALUOutE, writeDataE;
  logic [4:0]  writeRegE;
  logic        flushE, readyM;
  logic        readyE, validM, regWriteM, memToRegM, memWriteM;
  logic [31:0] ALUOutM, writeDataM;
  logic [4:0]  writeRegM;
  logic        fwdValid;
  logic [4:0]  fwdReg;
  logic [31:0] fwdData;
  logic [1:0]  occupancy;

  ex_mem_reg dut (
    .clk(clk), .resetN(resetN), .validE(validE), .regWriteE(regWriteE),
    .memToRegE(memToRegE), .memWriteE(memWriteE), .ALUOutE(ALUOutE),
    .writeDataE(writeDataE), .writeRegE(writeRegE), .flushE(flushE),
    .readyM(readyM), .readyE(readyE), .validM(validM), .regWriteM(regWriteM),
    .memToRegM(memToRegM), .memWriteM(memWriteM), .ALUOutM(ALUOutM),
    .writeDataM(writeDataM), .writeRegM(writeRegM), .fwdValid(fwdValid),
    .fwdReg(fwdReg), .fwdData(fwdData), .occupancy(occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit             rst_n;
    bit             valid;
    bit             flush;
    bit             ready_m;
    stage_payload_t p;
  } in_t;

  typedef struct {
    in_t         i;
    bit          e_valid;
    bit          e_mw;
    bit          e_fwd;
    logic [1:0]  e_occ;
    bit          chk_data;
    logic [31:0] e_alu;
    logic [31:0] e_wd;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  stage_payload_t mq[$];
  bit             m_rdy;
  bit             m_in;
  bit             m_out;
  stage_payload_t m_pay;
  logic [31:0]    got_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, got, exp);
  endtask

  function automatic in_t mk(input bit rst_n, input bit valid, input bit flush, input bit ready_m,
                             input bit rw, input bit m2r, input bit mw,
                             input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr);
    in_t x;
    x.rst_n = rst_n; x.valid = valid; x.flush = flush; x.ready_m = ready_m;
    x.p.regWrite = rw; x.p.memToReg = m2r; x.p.memWrite = mw;
    x.p.ALUOut = alu; x.p.writeData = wd; x.p.writeReg = wr;
    return x;
  endfunction

  function automatic vec_t mkv(input in_t x, input bit ev, input bit emw, input bit efwd,
                               input logic [1:0] eocc, input bit cd,
                               input logic [31:0] ealu, input logic [31:0] ewd);
    vec_t v;
    v.i = x; v.e_valid = ev; v.e_mw = emw; v.e_fwd = efwd; v.e_occ = eocc;
    v.chk_data = cd; v.e_alu = ealu; v.e_wd = ewd;
    return v;
  endfunction

  // Compare DUT against the queue model before the edge and decide the model's transfers.
  task automatic model_compare();
    bit exp_ready;
    bit has;
    stage_payload_t h;
    has = (mq.size() != 0);
`ifdef EX_MEM_SKID_EN
    exp_ready = m_rdy;
`else
    exp_ready = readyM || !has;
`endif
    chk("readyE", 32'(readyE), 32'(exp_ready));
    chk("validM", 32'(validM), 32'(has));
    chk("occupancy", 32'(occupancy), mq.size());
    if (has) begin
      h = mq[0];
      chk("regWriteM", 32'(regWriteM), 32'(h.regWrite));
      chk("memWriteM", 32'(memWriteM), 32'(h.memWrite));
      chk("memToRegM", 32'(memToRegM), 32'(h.memToReg));
      chk("ALUOutM", ALUOutM, h.ALUOut);
      chk("writeDataM", writeDataM, h.writeData);
      chk("writeRegM", 32'(writeRegM), 32'(h.writeReg));
      chk("fwdValid", 32'(fwdValid),
          32'(h.regWrite && !h.memToReg && h.writeReg != 5'd0));
      chk("fwdData", fwdData, h.ALUOut);
      chk("fwdReg", 32'(fwdReg), 32'(h.writeReg));
    end else begin
      chk("regWriteM_idle", 32'(regWriteM), 32'd0);
      chk("memWriteM_idle", 32'(memWriteM), 32'd0);
      chk("fwdValid_idle", 32'(fwdValid), 32'd0);
    end
    m_in  = validE && exp_ready && !flushE;
    m_out = has && readyM;
    if (validM && readyM) got_q.push_back(ALUOutM);
  endtask

  task automatic model_edge(input bit rst_n);
    if (!rst_n) begin
      mq.delete();
      m_rdy = 1'b1;
    end else begin
      if (m_out) void'(mq.pop_front());
      if (m_in) mq.push_back(m_pay);
      m_rdy = (mq.size() < 2);
    end
  endtask

  task automatic drive_cycle(input in_t x);
    resetN     = x.rst_n;
    validE     = x.valid;
    flushE     = x.flush;
    readyM     = x.ready_m;
    regWriteE  = x.p.regWrite;
    memToRegE  = x.p.memToReg;
    memWriteE  = x.p.memWrite;
    ALUOutE    = x.p.ALUOut;
    writeDataE = x.p.writeData;
    writeRegE  = x.p.writeReg;
    m_pay      = x.p;
    #1;
    model_compare();
    @(posedge clk);
    model_edge(x.rst_n);
    @(negedge clk);
  endtask

  function automatic in_t idle(input bit ready_m);
    return mk(1, 0, 0, ready_m, 0, 0, 0, 32'h0, 32'h0, 5'd0);
  endfunction

  vec_t vt[11];
  in_t  x;
  int   k;
  bit   b_taken;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 0; validE = 0; regWriteE = 0; memToRegE = 0; memWriteE = 0;
    ALUOutE = 0; writeDataE = 0; writeRegE = 0; flushE = 0; readyM = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_edge(1'b0);

    // Directed table: store, flush, forwarding corner cases, held entry under flush.
    vt[0]  = mkv(mk(0,1,0,1, 1,1,1, 32'h55, 32'h66, 5'd7), 0,0,0, 2'd0, 1, 32'h0, 32'h0);
    vt[1]  = mkv(mk(1,1,0,1, 0,0,1, 32'h10, 32'hDEADBEEF, 5'd0), 1,1,0, 2'd1, 1, 32'h10, 32'hDEADBEEF);
    vt[2]  = mkv(idle(1), 0,0,0, 2'd0, 0, 32'h0, 32'h0);
    vt[3]  = mkv(mk(1,1,1,1, 1,0,0, 32'h33, 32'h0, 5'd3), 0,0,0, 2'd0, 0, 32'h0, 32'h0);
    vt[4]  = mkv(mk(1,1,0,1, 1,0,0, 32'h2A, 32'h0, 5'd5), 1,0,1, 2'd1, 1, 32'h2A, 32'h0);
    vt[5]  = mkv(mk(1,1,0,1, 1,0,0, 32'h2B, 32'h0, 5'd0), 1,0,0, 2'd1, 1, 32'h2B, 32'h0);
    vt[6]  = mkv(mk(1,1,0,1, 1,1,0, 32'h2C, 32'h0, 5'd5), 1,0,0, 2'd1, 1, 32'h2C, 32'h0);
    vt[7]  = mkv(idle(1), 0,0,0, 2'd0, 0, 32'h0, 32'h0);
    vt[8]  = mkv(mk(1,1,0,0, 0,0,1, 32'h77, 32'h88, 5'd0), 1,1,0, 2'd1, 1, 32'h77, 32'h88);
    vt[9]  = mkv(mk(1,1,1,0, 1,0,1, 32'h99, 32'hAA, 5'd9), 1,1,0, 2'd1, 1, 32'h77, 32'h88);
    vt[10] = mkv(idle(1), 0,0,0, 2'd0, 0, 32'h0, 32'h0);

    for (int i = 0; i < 11; i++) begin
      drive_cycle(vt[i].i);
      chk($sformatf("tv%0d_validM", i), 32'(validM), 32'(vt[i].e_valid));
      chk($sformatf("tv%0d_memWriteM", i), 32'(memWriteM), 32'(vt[i].e_mw));
      chk($sformatf("tv%0d_fwdValid", i), 32'(fwdValid), 32'(vt[i].e_fwd));
      chk($sformatf("tv%0d_occupancy", i), 32'(occupancy), 32'(vt[i].e_occ));
      if (vt[i].chk_data) begin
        chk($sformatf("tv%0d_ALUOutM", i), ALUOutM, vt[i].e_alu);
        chk($sformatf("tv%0d_writeDataM", i), writeDataM, vt[i].e_wd);
      end
    end
    chk("tv_fwdReg_last5", 32'(writeRegM), 32'd0);

    // Back-pressure: A then B while memory stalls, then drain in order.
    got_q.delete();
    x = mk(1,1,0,0, 0,0,0, 32'd1, 32'h0, 5'd0);
    k = 0;
    do begin drive_cycle(x); k++; end while (!m_in && k < 5);
    chk("bp_acceptA", 32'(m_in), 32'd1);
    x = mk(1,1,0,0, 0,0,0, 32'd2, 32'h0, 5'd0);
    drive_cycle(x);
    b_taken = m_in;
`ifdef EX_MEM_SKID_EN
    chk("bp_occ2", 32'(occupancy), 32'd2);
    chk("bp_readyE0", 32'(readyE), 32'd0);
`else
    chk("bp_occ1", 32'(occupancy), 32'd1);
`endif
    chk("bp_held", ALUOutM, 32'd1);
    x.ready_m = 1'b1;
    k = 0;
    while (!b_taken && k < 5) begin drive_cycle(x); b_taken = m_in; k++; end
    chk("bp_acceptB", 32'(b_taken), 32'd1);
    repeat (4) drive_cycle(idle(1));
    chk("bp_count", got_q.size(), 32'd2);
    if (got_q.size() == 2) begin
      chk("bp_first", got_q[0], 32'd1);
      chk("bp_second", got_q[1], 32'd2);
    end

    // Reset in the middle of a stall overrides a simultaneous transfer.
    drive_cycle(mk(1,1,0,0, 1,0,1, 32'd5, 32'h5, 5'd4));
    drive_cycle(mk(1,1,0,0, 1,0,1, 32'd6, 32'h6, 5'd4));
    drive_cycle(mk(0,1,0,1, 1,1,1, 32'd7, 32'h7, 5'd4));
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_validM", 32'(validM), 32'd0);
    chk("rst_readyE", 32'(readyE), 32'd1);
    chk("rst_ALUOutM", ALUOutM, 32'd0);
    chk("rst_writeDataM", writeDataM, 32'd0);
    chk("rst_writeRegM", 32'(writeRegM), 32'd0);
    chk("rst_ctrl", 32'({regWriteM, memToRegM, memWriteM}), 32'd0);

    // Streaming: one result per cycle, in order, occupancy pinned at 1.
    got_q.delete();
    for (int i = 0; i < 100; i++) begin
      drive_cycle(mk(1,1,0,1, 1,0,0, 32'(1000 + i), 32'(i), 5'd1));
      chk("stream_occ", 32'(occupancy), 32'd1);
    end
    drive_cycle(idle(1));
    chk("stream_count", got_q.size(), 32'd100);
    for (int i = 0; i < 100 && i < got_q.size(); i++)
      chk("stream_order", got_q[i], 32'(1000 + i));

    // Random traffic against the queue model.
    for (int i = 0; i < 400; i++) begin
      x = mk(($urandom_range(49) != 0), ($urandom_range(9) < 7), ($urandom_range(9) == 0),
             ($urandom_range(9) < 6), 1'($urandom), 1'($urandom), 1'($urandom),
             $urandom, $urandom, ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom));
      drive_cycle(x);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; resetN  in  1  synchronous active-low reset.
REQ-002 SHALL have ports: validE  in  1  execute result present; regWriteE, memToRegE, memWriteE  in  1 each  control bits; ALUOutE  in  32  ALU result/address; writeDataE  in  32  store data; writeRegE  in  5  destination register.
REQ-003 SHALL have ports: flushE  in  1  squash the incoming execute result; readyM  in  1  memory stage accepts this cycle.
REQ-004 SHALL have ports: readyE  out  1  block accepts from execute; validM  out  1; regWriteM, memToRegM, memWriteM  out  1 each; ALUOutM  out  32; writeDataM  out  32; writeRegM  out  5.
REQ-005 SHALL have ports: fwdValid  out  1  forwardable result; fwdReg  out  5; fwdData  out  32; occupancy  out  2  entries held (0-2).

Function
REQ-006 Transfer in SHALL occur when validE && readyE && !flushE; transfer out when validM && readyM.
REQ-007 States SHALL be EMPTY (no entry), FULL (main register valid), SKID (main and skid valid).
REQ-008 EMPTY: transfer in -> FULL, capture into main; otherwise stay.
REQ-009 FULL: in without out -> SKID, capture into skid; out without in -> EMPTY; in and out -> FULL, main reloaded from E inputs; neither -> hold.
REQ-010 SKID: out -> FULL, skid contents move to main same edge; no out -> hold.
REQ-011 readyE SHALL be registered: 1 in EMPTY and FULL, 0 in SKID; no combinational path readyM -> readyE.
REQ-012 Latency SHALL be one cycle: data accepted at edge N appears on M outputs after edge N when state was EMPTY, or when FULL with simultaneous out.
REQ-013 M outputs SHALL always reflect the main register; when validM=0, regWriteM and memWriteM SHALL be forced 0.
REQ-014 flushE SHALL squash only the incoming entry; held entries SHALL be unaffected.
REQ-015 Held entry SHALL keep all M outputs bit-stable while validM && !readyM.
REQ-016 fwdValid SHALL equal validM && regWriteM && !memToRegM && (writeRegM != 0); fwdReg = writeRegM; fwdData = ALUOutM.
REQ-017 occupancy SHALL be 0/1/2 for EMPTY/FULL/SKID.
REQ-018 writeRegE = 0 with regWriteE = 1 SHALL be carried unchanged; only fwdValid suppresses it.

Reset
REQ-019 On resetN=0 at a rising edge: state EMPTY, validM=0, all control outputs 0, ALUOutM/writeDataM/writeRegM 0, skid cleared, readyE=1, occupancy=0.
REQ-020 Reset SHALL override any simultaneous transfer; entries in flight are discarded.

Configuration
REQ-021 Macro EX_MEM_SKID_EN defined: skid buffer and SKID state present as REQ-007..011.
REQ-022 Macro undefined: no skid storage, states EMPTY/FULL only, readyE = readyM || !validM (combinational), occupancy never 2; all other behaviour identical.

Structure
REQ-023 Shared pipeline package SHALL hold the state enum (EMPTY, FULL, SKID) and a packed stage-payload type {regWrite, memToReg, memWrite, ALUOut, writeData, writeReg} (72 bits).
REQ-024 One sub-module SHALL be natural: pipe_payload_reg (enable-loaded payload register with synchronous clear), instantiated for main and skid.

Verification
REQ-025 Reset then single store: validE=1, memWriteE=1, ALUOutE=0x00000010, writeDataE=0xDEADBEEF, readyM=1 -> next cycle validM=1, memWriteM=1, ALUOutM=0x10, writeDataM=0xDEADBEEF; following cycle validM=0.
REQ-026 Back-pressure: readyM=0, two back-to-back entries A(ALUOutE=1), B(ALUOutE=2) -> occupancy 2, readyE=0, ALUOutM=1 held; readyM=1 -> ALUOutM=1 leaves, then 2, no loss or duplication.
REQ-027 Flush: flushE=1 with validE=1 in EMPTY -> validM stays 0; in FULL with readyM=0 -> held entry unchanged, occupancy stays 1.
REQ-028 Forwarding: regWriteE=1, memToRegE=0, writeRegE=5, ALUOutE=0x2A -> fwdValid=1, fwdReg=5, fwdData=0x2A; same with writeRegE=0 or memToRegE=1 -> fwdValid=0.
REQ-029 Reset mid-operation: occupancy 2, resetN=0 one cycle -> occupancy 0, validM=0, readyE=1, outputs 0.
REQ-030 Streaming: validE=1, readyM=1 for 100 cycles with incrementing ALUOutE -> one output per cycle, in order, occupancy constant 1; repeat with EX_MEM_SKID_EN undefined, same sequence.
